uart_pwm_cmd: RTL and testbench

Command decoder and multi-channel PWM generator that sits directly downstream of the UART receiver. It consumes the receiver's one-cycle byte strobes and break indications and parses fixed-format frames of the form SYNC, CHANNEL, DUTY, optional CHECKSUM. Each valid frame updates one channel's duty cycle, and the block drives glitch-free PWM outputs whose duty changes only at a period boundary.

---
 rtl/uart_pwm_cmd.sv | 188 ++++++++++++++++++
 tb/tb_uart_pwm_cmd.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_pwm_cmd.sv
// uart_pwm_cmd: parses SYNC, CHANNEL, DUTY[, CHECKSUM] frames from a UART receiver and drives CHANNELS PWM outputs.
// Define UART_PWM_CHECKSUM_EN for 4-byte frames carrying an XOR checksum (CHANNEL ^ DUTY).
module uart_pwm_cmd #(
  parameter int         CHANNELS       = 4,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         PRESCALE       = 105,
  parameter int         TIMEOUT_CYCLES = 270000
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                rx_valid,
  input  logic [7:0]          rx_data,
  input  logic                rx_break,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                cmd_ok,
  output logic                frame_err
);

  localparam int              PS_W      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int              TO_W      = $clog2(TIMEOUT_CYCLES);
  localparam logic [PS_W-1:0] PS_LAST   = PS_W'(PRESCALE - 1);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]      PCNT_LAST = 8'd254;

`ifdef UART_PWM_CHECKSUM_EN
  typedef enum logic [1:0] {S_IDLE, S_CHAN, S_DUTY, S_CHK} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_CHAN, S_DUTY} state_t;
`endif

  state_t          state_q, state_d;
  logic [7:0]      chan_q, chan_d;
`ifdef UART_PWM_CHECKSUM_EN
  logic [7:0]      duty_q, duty_d;
`endif
  logic [TO_W-1:0] tmo_q, tmo_d;
  logic            cmd_ok_q, cmd_ok_d;
  logic            frame_err_q, frame_err_d;
  logic            wr_en;
  logic [7:0]      wr_data;
  logic            byte_in;
  logic            chan_in_range;

  assign byte_in       = rx_valid && !rx_break;
  assign chan_in_range = (32'(chan_q) < 32'(CHANNELS));

  // Priority: break, then an arriving byte, then the inter-byte timeout.
  always_comb begin
    state_d     = state_q;
    chan_d      = chan_q;
`ifdef UART_PWM_CHECKSUM_EN
    duty_d      = duty_q;
`endif
    tmo_d       = '0;
    cmd_ok_d    = 1'b0;
    frame_err_d = 1'b0;
    wr_en       = 1'b0;
    wr_data     = rx_data;
    if (rx_break) begin
      state_d = S_IDLE;
    end else if (byte_in) begin
      case (state_q)
        S_IDLE: begin
          if (rx_data == SYNC_BYTE) state_d = S_CHAN;
        end
        S_CHAN: begin
          chan_d  = rx_data;
          state_d = S_DUTY;
        end
`ifdef UART_PWM_CHECKSUM_EN
        S_DUTY: begin
          duty_d  = rx_data;
          state_d = S_CHK;
        end
        S_CHK: begin
          state_d = S_IDLE;
          wr_data = duty_q;
          if (chan_in_range && (rx_data == (chan_q ^ duty_q))) begin
            wr_en    = 1'b1;
            cmd_ok_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
`else
        S_DUTY: begin
          state_d = S_IDLE;
          if (chan_in_range) begin
            wr_en    = 1'b1;
            cmd_ok_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
`endif
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE) begin
      if (tmo_q == TO_LAST) begin
        state_d     = S_IDLE;
        frame_err_d = 1'b1;
      end else begin
        tmo_d = tmo_q + TO_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      chan_q      <= '0;
`ifdef UART_PWM_CHECKSUM_EN
      duty_q      <= '0;
`endif
      tmo_q       <= '0;
      cmd_ok_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      chan_q      <= chan_d;
`ifdef UART_PWM_CHECKSUM_EN
      duty_q      <= duty_d;
`endif
      tmo_q       <= tmo_d;
      cmd_ok_q    <= cmd_ok_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign cmd_ok    = cmd_ok_q;
  assign frame_err = frame_err_q;

  logic [PS_W-1:0] presc_q, presc_d;
  logic [7:0]      pcnt_q, pcnt_d;
  logic            tick;
  logic            wrap;

  assign tick = (presc_q == PS_LAST);
  assign wrap = tick && (pcnt_q == PCNT_LAST);

  // 255-tick period so that duty 255 keeps the output permanently high.
  always_comb begin
    presc_d = tick ? '0 : presc_q + PS_W'(1);
    pcnt_d  = pcnt_q;
    if (tick) pcnt_d = (pcnt_q == PCNT_LAST) ? 8'd0 : pcnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      presc_q <= '0;
      pcnt_q  <= '0;
    end else begin
      presc_q <= presc_d;
      pcnt_q  <= pcnt_d;
    end
  end

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      logic [7:0] shadow_q, shadow_d;
      logic [7:0] active_q, active_d;
      logic       pwm_q, pwm_d;

      // Active duty only changes at the wrap, so a period is never cut short.
      always_comb begin
        shadow_d = shadow_q;
        if (wr_en && (chan_q == 8'(gi))) shadow_d = wr_data;
        active_d = wrap ? shadow_q : active_q;
        pwm_d    = (pcnt_q < active_q);
      end

      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          shadow_q <= '0;
          active_q <= '0;
          pwm_q    <= 1'b0;
        end else begin
          shadow_q <= shadow_d;
          active_q <= active_d;
          pwm_q    <= pwm_d;
        end
      end

      assign pwm_out[gi] = pwm_q;
    end
  endgenerate

endmodule

// File: tb/tb_uart_pwm_cmd.sv
// Self-checking bench for uart_pwm_cmd; adapts frame format to UART_PWM_CHECKSUM_EN.
`timescale 1ns/1ps
module tb_uart_pwm_cmd;
  localparam int CH  = 4;
  localparam int P   = 4;
  localparam int TO  = 64;
  localparam int PER = 255 * P;

  logic          clk      = 1'b0;
  logic          resetn   = 1'b0;
  logic          rx_valid = 1'b0;
  logic          rx_break = 1'b0;
  logic [7:0]    rx_data  = 8'h00;
  logic [CH-1:0] pwm_out;
  logic          cmd_ok;
  logic          frame_err;

  int tests = 0;
  int fails = 0;
  int edge_n = 0;
  int wr_edge[$];
  int wr_ch[$];
  int wr_duty[$];
  int last_hi[CH];
  int last_rise[CH];

  uart_pwm_cmd #(
    .CHANNELS(CH), .SYNC_BYTE(8'hA5), .PRESCALE(P), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .resetn(resetn), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_break(rx_break), .pwm_out(pwm_out), .cmd_ok(cmd_ok), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Number of rising edges since reset release.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) edge_n <= 0;
    else         edge_n <= edge_n + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at edge %0d, required completion", edge_n);
    $fatal(1, "watchdog");
  end

  // Shadow duty of a channel once e edges have elapsed.
  function automatic int shadow_at(input int ch, input int e);
    int v = 0;
    for (int i = 0; i < wr_edge.size(); i++)
      if (wr_ch[i] == ch && wr_edge[i] <= e) v = wr_duty[i];
    return v;
  endfunction

  // Expected output after n edges: output shows the tick position and period duty of edge n-1.
  function automatic bit exp_pwm(input int ch, input int n);
    int m, k, pos, d;
    if (n == 0) return 1'b0;
    m   = n - 1;
    k   = m / PER;
    pos = (m / P) % 255;
    d   = (k == 0) ? 0 : shadow_at(ch, k * PER - 1);
    return pos < d;
  endfunction

  task automatic clear_model();
    wr_edge.delete(); wr_ch.delete(); wr_duty.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, output bit ok, output bit err);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    ok  = (cmd_ok === 1'b1);
    err = (frame_err === 1'b1);
  endtask

  task automatic send_frame(input int ch, input int duty, input int ck, input string name);
    bit ok, err, any, exp_ok;
    int e;
    any = 1'b0;
    send_byte(8'hA5, ok, err);    any |= ok | err;
    send_byte(8'(ch), ok, err);   any |= ok | err;
`ifdef UART_PWM_CHECKSUM_EN
    send_byte(8'(duty), ok, err); any |= ok | err;
    e = edge_n + 1;
    send_byte(8'(ck), ok, err);
    exp_ok = (ch < CH) && (ck == (ch ^ duty));
`else
    e = edge_n + 1;
    send_byte(8'(duty), ok, err);
    exp_ok = (ch < CH);
    if (ck < 0) exp_ok = 1'b0;
`endif
    tests++;
    if (any !== 1'b0) begin
      fails++;
      $display("FAIL %s early_pulse got=%0b want=0", name, any);
    end
    tests++;
    if (ok !== exp_ok || err !== !exp_ok) begin
      fails++;
      $display("FAIL %s verdict got cmd_ok=%0b frame_err=%0b want cmd_ok=%0b frame_err=%0b",
               name, ok, err, exp_ok, !exp_ok);
    end
    if (exp_ok) begin
      wr_edge.push_back(e); wr_ch.push_back(ch); wr_duty.push_back(duty);
    end
    $display("[TB] %s frame ch=%0d duty=%02h ck=%02h cmd_ok=%0b frame_err=%0b", name, ch, duty, ck & 255, ok, err);
  endtask

  task automatic check_pwm(input int ncyc, input string name);
    int bad[CH];
    for (int c = 0; c < CH; c++) bad[c] = 0;
    repeat (ncyc) begin
      @(negedge clk);
      for (int c = 0; c < CH; c++)
        if (pwm_out[c] !== exp_pwm(c, edge_n)) bad[c]++;
    end
    for (int c = 0; c < CH; c++) begin
      tests++;
      if (bad[c] != 0) begin
        fails++;
        $display("FAIL %s pwm[%0d] got %0d differing cycles want 0", name, c, bad[c]);
      end
    end
    $display("[TB] %s pwm waveform checked over %0d cycles", name, ncyc);
  endtask

  // Count high cycles and 0->1 transitions over the next whole PWM period.
  task automatic count_period(input string name);
    int k;
    int prev[CH];
    k = edge_n / PER + 1;
    for (int c = 0; c < CH; c++) begin last_hi[c] = 0; last_rise[c] = 0; prev[c] = -1; end
    while (edge_n < k * PER) @(negedge clk);
    repeat (PER) begin
      @(negedge clk);
      for (int c = 0; c < CH; c++) begin
        if (pwm_out[c] === 1'b1) begin
          last_hi[c]++;
          if (prev[c] == 0) last_rise[c]++;
          prev[c] = 1;
        end else begin
          prev[c] = 0;
        end
      end
    end
    for (int c = 0; c < CH; c++) begin
      tests++;
      if (last_hi[c] != shadow_at(c, k * PER - 1) * P) begin
        fails++;
        $display("FAIL %s high_count[%0d] got %0d want %0d", name, c, last_hi[c], shadow_at(c, k * PER - 1) * P);
      end
      tests++;
      if (last_rise[c] != 0) begin
        fails++;
        $display("FAIL %s runt_pulse[%0d] got %0d rises want 0", name, c, last_rise[c]);
      end
    end
    $display("[TB] %s period %0d high=%0d,%0d,%0d,%0d", name, k, last_hi[0], last_hi[1], last_hi[2], last_hi[3]);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (pwm_out !== '0 || cmd_ok !== 1'b0 || frame_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs got pwm=%b ok=%b err=%b want 0", pwm_out, cmd_ok, frame_err);
    end
    resetn = 1'b1;
    check_pwm(20, "reset_idle");
  endtask

  task automatic test_basic();
    send_frame(1, 8'h80, 8'h81, "basic_ok");
    @(negedge clk);
    tests++;
    if (cmd_ok !== 1'b0) begin
      fails++;
      $display("FAIL basic_pulse_width got cmd_ok=%b want 0", cmd_ok);
    end
    send_frame(2, 8'h40, 8'h00, "basic_badck");
    send_frame(7, 8'h10, 8'h17, "basic_badch");
    count_period("basic");
    tests++;
    if (last_hi[1] != 512) begin
      fails++;
      $display("FAIL basic_ch1_high got %0d want 512", last_hi[1]);
    end
    tests++;
`ifdef UART_PWM_CHECKSUM_EN
    if (last_hi[2] != 0) begin
      fails++;
      $display("FAIL basic_ch2_high got %0d want 0", last_hi[2]);
    end
`else
    if (last_hi[2] != 256) begin
      fails++;
      $display("FAIL basic_ch2_high got %0d want 256", last_hi[2]);
    end
`endif
  endtask

  task automatic test_break();
    bit ok, err, any;
    any = 1'b0;
    send_byte(8'hA5, ok, err); any |= ok | err;
    send_byte(8'h00, ok, err); any |= ok | err;
    rx_break = 1'b1; rx_valid = 1'b1; rx_data = 8'hFF;
    @(negedge clk);
    rx_break = 1'b0; rx_valid = 1'b0;
    any |= (cmd_ok === 1'b1) | (frame_err === 1'b1);
    repeat (3) begin
      @(negedge clk);
      any |= (cmd_ok === 1'b1) | (frame_err === 1'b1);
    end
    send_byte(8'h01, ok, err); any |= ok | err;
    send_byte(8'h80, ok, err); any |= ok | err;
    send_byte(8'h81, ok, err); any |= ok | err;
    @(negedge clk);
    any |= (cmd_ok === 1'b1) | (frame_err === 1'b1);
    tests++;
    if (any !== 1'b0) begin
      fails++;
      $display("FAIL break_no_pulse got pulse=%0b want 0", any);
    end
    $display("[TB] break sequence done pulse=%0b", any);
    send_frame(0, 8'hFF, 8'hFF, "break_after");
    count_period("break");
    tests++;
    if (last_hi[0] != PER) begin
      fails++;
      $display("FAIL break_ch0_const_high got %0d want %0d", last_hi[0], PER);
    end
  endtask

  task automatic test_timeout();
    bit ok, err;
    int cnt, first;
    send_byte(8'hA5, ok, err);
    send_byte(8'h03, ok, err);
    cnt = 0; first = -1;
    for (int i = 1; i <= TO + 8; i++) begin
      @(negedge clk);
      if (frame_err === 1'b1) begin
        cnt++;
        if (first < 0) first = i;
      end
    end
    tests++;
    if (cnt != 1) begin
      fails++;
      $display("FAIL timeout_count got %0d pulses want 1", cnt);
    end
    tests++;
    if (first != TO) begin
      fails++;
      $display("FAIL timeout_latency got %0d want %0d", first, TO);
    end
    $display("[TB] timeout pulses=%0d at cycle %0d", cnt, first);
    send_frame(3, 8'h00, 8'h03, "timeout_after");
    count_period("timeout");
    tests++;
    if (last_hi[3] != 0) begin
      fails++;
      $display("FAIL timeout_ch3_low got %0d want 0", last_hi[3]);
    end
  endtask

  task automatic test_mid_period();
    while (edge_n % PER != 450) @(negedge clk);
    send_frame(0, 8'h20, 8'h20, "mid_a");
    repeat (40) @(negedge clk);
    send_frame(0, 8'hC0, 8'hC0, "mid_b");
    tests++;
    if (pwm_out[0] !== 1'b1) begin
      fails++;
      $display("FAIL mid_unchanged got %b want 1", pwm_out[0]);
    end
    check_pwm(200, "mid_hold");
    count_period("mid");
    tests++;
    if (last_hi[0] != 8'hC0 * P) begin
      fails++;
      $display("FAIL mid_ch0_high got %0d want %0d", last_hi[0], 8'hC0 * P);
    end
  endtask

  task automatic test_back_to_back();
    send_frame(1, 8'h11, 8'h10, "b2b_1");
    send_frame(2, 8'h7F, 8'h7D, "b2b_2");
    send_frame(3, 8'hFE, 8'hFD, "b2b_3");
    count_period("b2b");
  endtask

  task automatic test_random();
    int ch, duty, ck;
    for (int t = 0; t < 25; t++) begin
      ch   = $urandom_range(0, 5);
      duty = $urandom_range(0, 255);
      ck   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : (ch ^ duty);
      send_frame(ch, duty, ck, "random");
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end
    check_pwm(2 * PER + 100, "random");
  endtask

  task automatic test_reset_mid_frame();
    bit ok, err, any;
    send_byte(8'hA5, ok, err);
    send_byte(8'h01, ok, err);
    #2 resetn = 1'b0;
    #1;
    tests++;
    if (pwm_out !== '0 || cmd_ok !== 1'b0 || frame_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_async got pwm=%b ok=%b err=%b want 0", pwm_out, cmd_ok, frame_err);
    end
    clear_model();
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    any = 1'b0;
    send_byte(8'h10, ok, err); any |= ok | err;
    send_byte(8'h11, ok, err); any |= ok | err;
    @(negedge clk);
    any |= (cmd_ok === 1'b1) | (frame_err === 1'b1);
    tests++;
    if (any !== 1'b0) begin
      fails++;
      $display("FAIL reset_partial_discard got pulse=%0b want 0", any);
    end
    send_frame(1, 8'h40, 8'h41, "reset_after");
    check_pwm(PER + 200, "reset_after");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_break();
    test_timeout();
    test_mid_period();
    test_back_to_back();
    test_random();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
